// File: rtl/anita3_l1_scaler_bank.sv
// rtl/anita3_l1_scaler_bank.sv - per-period saturating edge scalers for the L1 trigger pipe
// ch0..2 count TRIGGER_PULSE[0..2] rising edges, ch3 counts L1; REF_PULSE edges close each gate period.
module anita3_l1_scaler_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ref_pulse_i,
  input  logic [2:0]       trigger_pulse_i,
  input  logic             l1_i,
  input  logic [1:0]       scaler_sel_i,
  output logic [WIDTH-1:0] scaler_data_o,
  output logic             scaler_valid_o,
  output logic [3:0]       overflow_o,
  output logic             mon_scaler_o
);

  localparam int N_CHAN = 4;

  typedef enum logic {
    WAIT_REF,
    COUNTING
  } state_t;

  state_t state_q, state_d;

  logic [N_CHAN-1:0]             in_prev_q;
  logic [N_CHAN-1:0]             ch_edge_q;
  logic                          ref_prev_q;
  logic                          ref_edge_q;
  logic [N_CHAN-1:0][WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_CHAN-1:0]             sticky_q, sticky_d;
  logic [N_CHAN-1:0][WIDTH-1:0]  hold_q, hold_d;
  logic [N_CHAN-1:0]             ovf_q, ovf_d;
  logic                          latch_q, latch_d;
  logic                          valid_q;
  logic [WIDTH-1:0]              data_q;
  logic                          mon_q;
  logic [N_CHAN-1:0][WIDTH-1:0]  sat_cnt;
  logic [N_CHAN-1:0]             sat_flag;
  logic [N_CHAN-1:0]             chan_in;

  assign chan_in = {l1_i, trigger_pulse_i};

  // Edges are registered so channel and REF edges reach the counters on the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_prev_q  <= '0;
      ch_edge_q  <= '0;
      ref_prev_q <= 1'b0;
      ref_edge_q <= 1'b0;
      mon_q      <= 1'b0;
    end else begin
      in_prev_q  <= chan_in;
      ch_edge_q  <= chan_in & ~in_prev_q;
      ref_prev_q <= ref_pulse_i;
      ref_edge_q <= ref_pulse_i & ~ref_prev_q;
      mon_q      <= l1_i & ~in_prev_q[3];
    end
  end

  always_comb begin
    sat_cnt  = cnt_q;
    sat_flag = sticky_q;
    for (int ch = 0; ch < N_CHAN; ch++) begin
      if (ch_edge_q[ch]) begin
        if (cnt_q[ch] == {WIDTH{1'b1}}) begin
          sat_flag[ch] = 1'b1;
        end else begin
          sat_cnt[ch] = cnt_q[ch] + WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q;
    latch_d  = 1'b0;
    case (state_q)
      WAIT_REF: begin
        cnt_d    = '0;
        sticky_d = '0;
        if (ref_edge_q) state_d = COUNTING;
      end
      COUNTING: begin
        // A channel edge coincident with REF is folded into the closing period.
        if (ref_edge_q) begin
          hold_d   = sat_cnt;
          ovf_d    = sat_flag;
          cnt_d    = '0;
          sticky_d = '0;
          latch_d  = 1'b1;
        end else begin
          cnt_d    = sat_cnt;
          sticky_d = sat_flag;
        end
      end
      default: state_d = WAIT_REF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= WAIT_REF;
      cnt_q    <= '0;
      sticky_q <= '0;
      hold_q   <= '0;
      ovf_q    <= '0;
      latch_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      latch_q  <= latch_d;
      valid_q  <= latch_q;
      data_q   <= hold_q[scaler_sel_i];
    end
  end

  assign scaler_data_o  = data_q;
  assign scaler_valid_o = valid_q;
  assign overflow_o     = ovf_q;
  assign mon_scaler_o   = mon_q;

endmodule

// File: tb/tb_anita3_l1_scaler_bank.sv
// tb/tb_anita3_l1_scaler_bank.sv - scenario and randomized checks of the L1 scaler bank
// Reference model counts rising edges per gate period with plain integers and saturates at readout.
module tb_anita3_l1_scaler_bank;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ref_p;
  logic [2:0]   trig;
  logic         l1;
  logic [1:0]   sel;
  logic [W-1:0] data;
  logic         valid;
  logic [3:0]   ovf;
  logic         mon;

  anita3_l1_scaler_bank #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .ref_pulse_i(ref_p), .trigger_pulse_i(trig),
    .l1_i(l1), .scaler_sel_i(sel), .scaler_data_o(data),
    .scaler_valid_o(valid), .overflow_o(ovf), .mon_scaler_o(mon)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0][W-1:0] h;
    logic [3:0]        o;
  } latch_t;

  bit       started;
  int       cnt [4];
  bit       p_ref, p_l1;
  bit [2:0] p_trig;
  bit       l_m1, l_m2;
  latch_t   lq [$];
  int       n_valid, n_mon;

  task automatic model_reset();
    started = 0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    p_ref = 0; p_l1 = 0; p_trig = 3'b0;
    l_m1 = 0; l_m2 = 0;
    lq.delete();
  endtask

  // One clock of stimulus; the model decides what the DUT must show after the edge.
  task automatic cycle(input bit r, input bit [2:0] t, input bit l);
    bit [3:0] e;
    bit       re, lk;
    latch_t   nl, ol;
    ref_p = r; trig = t; l1 = l;
    e  = {l & ~p_l1, t & ~p_trig};
    re = r & ~p_ref;
    p_l1 = l; p_trig = t; p_ref = r;
    lk = 0;
    if (started) for (int c = 0; c < 4; c++) if (e[c]) cnt[c]++;
    if (re) begin
      if (started) begin
        for (int c = 0; c < 4; c++) begin
          nl.h[c] = (cnt[c] > MAXV) ? W'(MAXV) : W'(cnt[c]);
          nl.o[c] = cnt[c] > MAXV;
          cnt[c]  = 0;
        end
        lq.push_back(nl);
        lk = 1;
      end else begin
        started = 1;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
      end
    end
    @(posedge clk); #1;
    total++;
    if (mon !== e[3]) begin bad++; $display("FAIL mon_scaler got=%0b exp=%0b", mon, e[3]); end
    if (mon === 1'b1) n_mon++;
    total++;
    if (valid !== l_m2) begin bad++; $display("FAIL scaler_valid got=%0b exp=%0b", valid, l_m2); end
    if (valid === 1'b1) n_valid++;
    if (l_m2 && lq.size() > 0) begin
      ol = lq.pop_front();
      total++;
      if (data !== ol.h[sel]) begin bad++; $display("FAIL valid_data sel=%0d got=%0d exp=%0d", sel, data, ol.h[sel]); end
      total++;
      if (ovf !== ol.o) begin bad++; $display("FAIL valid_overflow got=%b exp=%b", ovf, ol.o); end
    end
    l_m2 = l_m1; l_m1 = lk;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'b0, 0);
  endtask

  task automatic read_ch(input logic [1:0] s, output logic [W-1:0] d);
    sel = s;
    cycle(0, 3'b0, 0);
    d = data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; ref_p = 0; trig = 3'b0; l1 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; ref_p = 0; trig = 3'b0; l1 = 0; sel = 2'd0;
    model_reset();
    #1;
    total++;
    if ({data, valid, ovf, mon} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {data, valid, ovf, mon}); end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic_l1();
    int v0, m0;
    logic [W-1:0] d;
    apply_reset();
    sel = 2'd3;
    cycle(1, 3'b0, 0);
    idle(2);
    v0 = n_valid; m0 = n_mon;
    for (int i = 0; i < 5; i++) begin cycle(0, 3'b0, 1); cycle(0, 3'b0, 0); end
    cycle(1, 3'b0, 0);
    idle(3);
    total++;
    if (n_valid - v0 != 1) begin bad++; $display("FAIL basic_valid_count got=%0d exp=1", n_valid - v0); end
    total++;
    if (n_mon - m0 != 5) begin bad++; $display("FAIL basic_mon_count got=%0d exp=5", n_mon - m0); end
    read_ch(2'd3, d);
    total++;
    if (d !== W'(5)) begin bad++; $display("FAIL basic_ch3 got=%0d exp=5", d); end
    total++;
    if (ovf !== 4'b0) begin bad++; $display("FAIL basic_overflow got=%b exp=0000", ovf); end
  endtask

  task automatic test_first_period();
    int v0;
    logic [W-1:0] d;
    apply_reset();
    sel = 2'd0;
    v0 = n_valid;
    for (int i = 0; i < 3; i++) begin cycle(0, 3'b001, 0); cycle(0, 3'b0, 0); end
    cycle(1, 3'b0, 0);
    idle(3);
    total++;
    if (n_valid != v0) begin bad++; $display("FAIL first_ref_valid got=%0d exp=0", n_valid - v0); end
    cycle(1, 3'b0, 0);
    idle(3);
    total++;
    if (n_valid - v0 != 1) begin bad++; $display("FAIL second_ref_valid got=%0d exp=1", n_valid - v0); end
    read_ch(2'd0, d);
    total++;
    if (d !== W'(0)) begin bad++; $display("FAIL first_period_ch0 got=%0d exp=0", d); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] d;
    sel = 2'd1;
    for (int i = 0; i < 20; i++) begin cycle(0, 3'b010, 0); cycle(0, 3'b0, 0); end
    cycle(1, 3'b0, 0);
    idle(3);
    read_ch(2'd1, d);
    total++;
    if (d !== W'(MAXV)) begin bad++; $display("FAIL sat_ch1 got=%0d exp=%0d", d, MAXV); end
    total++;
    if (ovf !== 4'b0010) begin bad++; $display("FAIL sat_overflow got=%b exp=0010", ovf); end
    for (int i = 0; i < 2; i++) begin cycle(0, 3'b010, 0); cycle(0, 3'b0, 0); end
    cycle(1, 3'b0, 0);
    idle(3);
    read_ch(2'd1, d);
    total++;
    if (d !== W'(2)) begin bad++; $display("FAIL post_sat_ch1 got=%0d exp=2", d); end
    total++;
    if (ovf !== 4'b0) begin bad++; $display("FAIL post_sat_overflow got=%b exp=0000", ovf); end
  endtask

  task automatic test_coincident_edge();
    logic [W-1:0] d;
    sel = 2'd2;
    for (int i = 0; i < 7; i++) begin cycle(0, 3'b100, 0); cycle(0, 3'b0, 0); end
    cycle(1, 3'b100, 0);
    idle(3);
    read_ch(2'd2, d);
    total++;
    if (d !== W'(8)) begin bad++; $display("FAIL coincident_ch2 got=%0d exp=8", d); end
    cycle(1, 3'b0, 0);
    idle(3);
    read_ch(2'd2, d);
    total++;
    if (d !== W'(0)) begin bad++; $display("FAIL next_period_ch2 got=%0d exp=0", d); end
  endtask

  task automatic test_held_and_repeat();
    logic [W-1:0] d;
    bit [2:0] pat [10] = '{3'b011, 3'b010, 3'b011, 3'b010, 3'b010,
                           3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    for (int i = 0; i < 10; i++) cycle(0, pat[i], 0);
    cycle(0, 3'b0, 0);
    cycle(1, 3'b0, 0);
    idle(3);
    read_ch(2'd1, d);
    total++;
    if (d !== W'(1)) begin bad++; $display("FAIL held_ch1 got=%0d exp=1", d); end
    read_ch(2'd0, d);
    total++;
    if (d !== W'(2)) begin bad++; $display("FAIL repeat_ch0 got=%0d exp=2", d); end
  endtask

  task automatic test_reset_mid_period();
    int v0;
    logic [W-1:0] d;
    sel = 2'd0;
    for (int i = 0; i < 9; i++) begin cycle(0, 3'b001, 0); cycle(0, 3'b0, 0); end
    cycle(1, 3'b0, 0);
    for (int i = 0; i < 9; i++) begin cycle(0, 3'b001, 1); cycle(0, 3'b0, 0); end
    cycle(0, 3'b0, 1);
    #2;
    rst = 1; ref_p = 0; trig = 3'b0; l1 = 0;
    #1;
    total++;
    if ({data, valid, ovf, mon} !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", {data, valid, ovf, mon}); end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    v0 = n_valid;
    cycle(1, 3'b0, 0);
    idle(3);
    total++;
    if (n_valid != v0) begin bad++; $display("FAIL post_reset_valid got=%0d exp=0", n_valid - v0); end
    for (int c = 0; c < 4; c++) begin
      read_ch(2'(c), d);
      total++;
      if (d !== W'(0)) begin bad++; $display("FAIL post_reset_hold ch=%0d got=%0d exp=0", c, d); end
    end
  endtask

  task automatic test_random();
    bit r;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 14) == 0);
      sel = 2'($urandom_range(0, 3));
      cycle(r, 3'($urandom), 1'($urandom));
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_basic_l1();
    test_first_period();
    test_saturation();
    test_coincident_edge();
    test_held_and_repeat();
    test_reset_mid_period();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
